// File: rtl/jk_counter_bank.sv
// rtl/jk_counter_bank.sv - WIDTH-bit JK register bank with mod-MODULUS up/down count, load, tc and optional sticky ovf (JK_BANK_OVF_EN)
module jk_counter_bank #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             ovf
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Top count value held one bit wider so MODULUS = 2**WIDTH needs no special case.
    localparam logic [WIDTH:0] C_MAX = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_MAX_Q = C_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE   = {{(WIDTH - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   w_q_ext;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_above;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next;

    assign w_q_ext   = {1'b0, r_q};
    assign w_at_max  = (w_q_ext == C_MAX);
    assign w_at_zero = (r_q == '0);
    assign w_above   = (w_q_ext > C_MAX);

    // A wrap is the enabled step from the top of the range in up mode or from zero in down mode.
    assign w_wrap = en & (((mode == MODE_UP) & w_at_max) | ((mode == MODE_DOWN) & w_at_zero));

    // Next-state selection per mode; increments/decrements only happen strictly inside the range, so no carry escapes.
    always_comb begin
        w_next = r_q;
        case (mode)
            MODE_JK:   w_next = (j & ~r_q) | (~k & r_q);
            MODE_UP: begin
                if (w_at_max || w_above) w_next = '0;
                else                     w_next = r_q + C_ONE;
            end
            MODE_DOWN: begin
                if (w_above || w_at_zero) w_next = C_MAX_Q;
                else                      w_next = r_q - C_ONE;
            end
            MODE_LOAD: w_next = j;
            default:   w_next = r_q;
        endcase
    end

    // State register: reset first, then enable hold, then the mode's next state.
    always_ff @(posedge clk) begin
        if (reset)   r_q <= '0;
        else if (en) r_q <= w_next;
    end

    assign q  = r_q;
    assign qn = ~r_q;
    assign tc = ~reset & w_wrap;

`ifdef JK_BANK_OVF_EN
    logic r_ovf;

    // Sticky wrap flag; a wrap on the same edge as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset)        r_ovf <= 1'b0;
        else if (w_wrap)  r_ovf <= 1'b1;
        else if (clr_ovf) r_ovf <= 1'b0;
    end

    assign ovf = r_ovf;
`else
    // No flag register in this build; clr_ovf has no effect.
    assign ovf = clr_ovf & 1'b0;
`endif

endmodule

// File: tb/tb_jk_counter_bank.sv
// tb/tb_jk_counter_bank.sv - scoreboard bench for jk_counter_bank (WIDTH=4, MODULUS=10)
module tb_jk_counter_bank;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         clr_ovf;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         tc;
    logic         ovf;

    jk_counter_bank #(.WIDTH(W), .MODULUS(M)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .clr_ovf (clr_ovf),
        .q       (q),
        .qn      (qn),
        .tc      (tc),
        .ovf     (ovf)
    );

    always #8 clk = ~clk;

    typedef struct {
        int q;
        int qn;
        int tc;
        int ovf;
        int step;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_steps  = 0;

    int   m_q   = 0;
    int   m_ovf = 0;

    task automatic chk(input string name, input int step, input logic [15:0] act, input int exp);
        n_checks++;
        if (act !== 16'(exp))
            $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare it mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q",   e.step, 16'(q),   e.q);
            chk("qn",  e.step, 16'(qn),  e.qn);
            chk("tc",  e.step, 16'(tc),  e.tc);
            chk("ovf", e.step, 16'(ovf), e.ovf);
        end
    end

    // Apply one cycle of inputs, record the outputs expected during this cycle, then advance the model.
    task automatic step(input bit rst, input bit e, input bit [1:0] md,
                        input bit [3:0] jj, input bit [3:0] kk, input bit clr);
        exp_t x;
        bit   wrap;
        int   nq;
        @(posedge clk);
        #2;
        reset = rst; en = e; mode = md; j = jj; k = kk; clr_ovf = clr;

        wrap = e && ((md == 2'd1 && m_q == M - 1) || (md == 2'd2 && m_q == 0));
        x.q    = m_q;
        x.qn   = 15 - m_q;
        x.tc   = (!rst && wrap) ? 1 : 0;
        x.ovf  = m_ovf;
        x.step = n_steps;
        exp_q.push_back(x);
        n_steps++;

        if (rst) begin
            m_q   = 0;
            m_ovf = 0;
        end else begin
            nq = m_q;
            if (e) begin
                case (md)
                    2'd0: begin
                        for (int b = 0; b < W; b++) begin
                            case ({jj[b], kk[b]})
                                2'b10: nq = nq | (1 << b);
                                2'b01: nq = nq & ~(1 << b);
                                2'b11: nq = nq ^ (1 << b);
                                default: ;
                            endcase
                        end
                    end
                    2'd1: nq = (m_q >= M - 1) ? 0 : m_q + 1;
                    2'd2: nq = (m_q == 0 || m_q > M - 1) ? M - 1 : m_q - 1;
                    default: nq = int'(jj);
                endcase
            end
            m_q = nq;
`ifdef JK_BANK_OVF_EN
            if (wrap)     m_ovf = 1;
            else if (clr) m_ovf = 0;
`endif
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 2'b00; j = 4'hF; k = 4'h0; clr_ovf = 1'b0;

        // Reset held for three edges with J pushing all ones.
        repeat (3) step(1, 1, 2'b00, 4'hF, 4'h0, 0);

        // JK: set/clear/toggle, then hold.
        step(0, 1, 2'b00, 4'b1010, 4'b0110, 0);
        step(0, 1, 2'b00, 4'b1010, 4'b0110, 0);
        repeat (2) step(0, 1, 2'b00, 4'b0000, 4'b0000, 0);

        // Up count from zero through the wrap, then ovf persists until cleared.
        step(1, 1, 2'b00, 4'h0, 4'h0, 0);
        repeat (11) step(0, 1, 2'b01, 4'h0, 4'h0, 0);
        step(0, 1, 2'b00, 4'h0, 4'h0, 1);
        step(0, 1, 2'b00, 4'h0, 4'h0, 0);

        // Down count from zero wraps to 9.
        step(1, 1, 2'b00, 4'h0, 4'h0, 0);
        repeat (12) step(0, 1, 2'b10, 4'h0, 4'h0, 0);

        // Out-of-range load then up, and again then down.
        step(0, 1, 2'b11, 4'd12, 4'h0, 0);
        step(0, 1, 2'b01, 4'h0, 4'h0, 0);
        step(0, 1, 2'b11, 4'd12, 4'h0, 0);
        step(0, 1, 2'b10, 4'h0, 4'h0, 0);
        step(0, 1, 2'b11, 4'd15, 4'h0, 0);
        step(0, 1, 2'b10, 4'h0, 4'h0, 0);

        // Enable low at 5, then count to 7 and reset mid-count.
        step(0, 1, 2'b11, 4'd5, 4'h0, 0);
        repeat (4) step(0, 0, 2'b01, 4'h0, 4'h0, 0);
        step(0, 0, 2'b10, 4'h0, 4'h0, 0);
        repeat (2) step(0, 1, 2'b01, 4'h0, 4'h0, 0);
        step(1, 1, 2'b01, 4'h0, 4'h0, 0);

        // Wrap condition with en low, then clr_ovf coinciding with a wrap.
        step(0, 1, 2'b11, 4'd9, 4'h0, 0);
        step(0, 0, 2'b01, 4'h0, 4'h0, 0);
        step(0, 1, 2'b01, 4'h0, 4'h0, 1);
        step(0, 1, 2'b00, 4'h0, 4'h0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom),
                 4'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        // Let the monitor drain the scoreboard within a bounded wait.
        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk);
        #1;
        chk("scoreboard_drained", n_steps, 16'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jk_counter_bank.md
# jk_counter_bank

Parametrised synchronous register of WIDTH JK flip-flops with true and complement outputs. It is the multi-bit successor to the single JK flip-flop in the Digital Logic experiments. The bank has four modes:
- raw per-bit JK
- modulo-MODULUS up-count
- modulo-MODULUS down-count
- parallel load

It also provides a terminal-count flag and an optional sticky overflow flag. It serves as the general counter/register primitive for the later sequential-logic experiments.

## Interface
Parameters:
- WIDTH, 4, number of JK cells; 1..16
- MODULUS, 2**WIDTH, count modulus for modes 01/10; legal range 2..2**WIDTH

Ports:
- clk  input  1  rising-edge clock, the block's only clock
- reset  input  1  synchronous, active-high; highest priority
- en  input  1  clock enable; 0 holds q in every mode
- mode  input  2  00 JK, 01 up, 10 down, 11 load
- j  input  WIDTH  per-bit J in mode 00; load data in mode 11
- k  input  WIDTH  per-bit K in mode 00; ignored in other modes
- clr_ovf  input  1  clears ovf (only active when JK_BANK_OVF_EN is defined)
- q  output  WIDTH  registered state
- qn  output  WIDTH  always ~q
- tc  output  1  combinational terminal count
- ovf  output  1  sticky wrap flag

## Operation
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Priority at each rising edge: reset, then en = 0 (hold), then mode.
- Reset values: q = 0, qn = all ones, ovf = 0. tc = 0 while reset is high.
- Mode 00 (JK), per bit i, given as {j[i], k[i]}:
  - 00: hold
  - 10: set to 1
  - 01: clear to 0
  - 11: toggle
  - The result is not range-checked; q may exceed MODULUS-1.
- Mode 01 (up):
  - q < MODULUS-1: q+1.
  - q == MODULUS-1: 0, and this is a wrap event.
  - q > MODULUS-1: 0. This is not a wrap event.
- Mode 10 (down):
  - 0 < q ≤ MODULUS-1: q-1.
  - q == 0: MODULUS-1, and this is a wrap event.
  - q > MODULUS-1: MODULUS-1. This is not a wrap event.
- Mode 11 (load): q <= j, equivalent to J = j, K = ~j. Out-of-range values are loaded as-is.
- tc = en & ~reset & ((mode == 01 & q == MODULUS-1) | (mode == 10 & q == 0)). In modes 00 and 11, tc = 0.
- Arithmetic is done in WIDTH+1 bits internally, so MODULUS = 2**WIDTH needs no special case. Carries are discarded.
- ovf:
  - Set at the edge where a wrap event occurs.
  - Cleared by reset or by clr_ovf.
  - If clr_ovf and a wrap event coincide, the set wins.

## Timing
- q changes one cycle after the sampling edge; there is no other latency.
- qn and tc are combinational from registered q and the current inputs, and are valid in the same cycle.
- Reset asserted mid-count: q = 0 at the next edge regardless of en/mode. Inputs are ignored while reset is high.
- Mode may change on any cycle. The new mode applies at the next edge with no flush and no dead cycle.
- en = 0 with a wrap condition present: no wrap, no ovf set, tc = 0.

## Configuration
- Macro: JK_BANK_OVF_EN.
- Defined: ovf is implemented as a sticky register with the set/clear rules above; clr_ovf is functional.
- Undefined: no ovf register is built; ovf is tied to 0 and clr_ovf is ignored. All other behaviour is identical.

## Test plan
All scenarios use WIDTH = 4, MODULUS = 10, clk period 16 ns.
- Reset: reset = 1 for 3 edges with en = 1, mode = 00, j = 4'hF, k = 0 -> q = 0, qn = 4'hF, tc = 0, ovf = 0 throughout.
- JK mode: q = 0, en = 1, mode = 00, j = 4'b1010, k = 4'b0110 -> q = 4'b1010 after edge 1, q = 4'b1000 after edge 2 (bit 1 toggles back). j = k = 0 -> q holds.
- Up count: from 0, mode = 01 for 10 edges -> q steps 1..9 then 0. tc = 1 only while q = 9. ovf = 1 after the 9->0 edge and stays 1 until clr_ovf; with the macro undefined, ovf stays 0.
- Down count: from 0, mode = 10 -> q = 9 with ovf = 1. Continuing gives 8, 7, ...; tc = 1 only while q = 0.
- Out-of-range load: mode = 11, j = 4'd12 -> q = 12. Then mode = 01 -> q = 0 with ovf unchanged. Reload 12, then mode = 10 -> q = 9.
- Enable and reset: en = 0 at q = 5 for 4 edges -> q = 5 and tc = 0. Then en = 1, mode = 01, and reset = 1 at q = 7 -> q = 0 at the next edge and ovf = 0. clr_ovf and a wrap on the same edge -> ovf = 1.
